// File: rtl/nubus_pkg.sv
// Shared NuBus slave definitions: response status codes, slot-space prefix,
// controller states and the block-length decode used when NUBUS_SLAVE_BLOCK_EN is defined.
package nubus_pkg;

   // Response status as driven on {tm1, tm0} during the acknowledge cycle
   typedef enum logic [1:0] {
      STAT_COMPLETE = 2'b00,
      STAT_ERROR    = 2'b01,
      STAT_TIMEOUT  = 2'b10,
      STAT_TRYAGAIN = 2'b11
   } nub_status_t;

   localparam logic [3:0] SLOT_PREFIX = 4'hF;

   typedef enum logic [2:0] {
      S_IDLE,
      S_WDATA,
      S_WB,
      S_RESP,
      S_BEAT
   } nub_state_t;

   // Returns {valid, last_beat_index} for the one-hot block length code in ad[5:2]
   function automatic logic [4:0] blk_decode(input logic [3:0] code);
      case (code)
         4'b0001: return {1'b1, 4'd1};
         4'b0010: return {1'b1, 4'd3};
         4'b0100: return {1'b1, 4'd7};
         4'b1000: return {1'b1, 4'd15};
         default: return {1'b0, 4'd0};
      endcase
   endfunction

endpackage

// File: rtl/nubus_slave_timer.sv
// Loadable down-counter bounding the Wishbone wait; expired is high once the count reaches zero.
module nubus_slave_timer #(
   parameter int W = 8
) (
   input  logic         nub_clkn,
   input  logic         nub_resetn,
   input  logic         load,
   input  logic         en,
   input  logic [W-1:0] load_val,
   output logic         expired
);

   logic [W-1:0] count;

   always_ff @(negedge nub_clkn or negedge nub_resetn) begin
      if (!nub_resetn)
         count <= '0;
      else if (load)
         count <= load_val;
      else if (en && (count != '0))
         count <= count - W'(1);
   end

   assign expired = (count == '0);

endmodule

// File: rtl/nubus_slave_ctrl.sv
// NuBus slot slave bridging claimed cycles to a Wishbone master port, all state on the falling edge.
// Define NUBUS_SLAVE_BLOCK_EN to accept block transfers; otherwise they are answered with Error.
module nubus_slave_ctrl
   import nubus_pkg::*;
#(
   parameter int TIMEOUT = 200
) (
   input  logic        nub_clkn,
   input  logic        nub_resetn,
   input  logic [3:0]  id,
   input  logic        tm0,
   input  logic        tm1,
   input  logic        start,
   input  logic        ack,
   input  logic [31:0] ad,
   input  logic [3:0]  sel,
   input  logic        block,
   output logic        wb_cyc,
   output logic        wb_stb,
   output logic        wb_we,
   output logic [29:0] wb_adr,
   output logic [31:0] wb_dat_w,
   output logic [3:0]  wb_sel,
   input  logic [31:0] wb_dat_r,
   input  logic        wb_ack,
   input  logic        wb_err,
   output logic        ack_o,
   output logic        tm0_o,
   output logic        tm1_o,
   output logic [31:0] ad_o,
   output logic        ad_oe
);

   localparam int TW = $clog2(TIMEOUT + 1);

   nub_state_t  state, state_nxt;
   nub_status_t status;
   logic        is_write;
   logic        claim;
   logic        blk_reject;
   logic        more_beats;
   logic        tmr_expired;

   // Transfer size is already encoded in sel, so tm0 carries nothing extra here
   logic unused_tm0;
   assign unused_tm0 = tm0;

   assign claim = start & ~ack & (ad[31:24] == {SLOT_PREFIX, id});

`ifdef NUBUS_SLAVE_BLOCK_EN
   logic       is_block;
   logic [3:0] beat_idx;
   logic [3:0] beat_last;
   logic [4:0] blk_info;

   assign blk_info   = blk_decode(ad[5:2]);
   assign blk_reject = block & ~blk_info[4];
   assign more_beats = is_block & (beat_idx != beat_last);
`else
   assign blk_reject = block;
   assign more_beats = 1'b0;
`endif

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (claim) state_nxt = blk_reject ? S_RESP : (tm1 ? S_WDATA : S_WB);
         S_WDATA: state_nxt = S_WB;
         S_WB: begin
            if (wb_err)
               state_nxt = S_RESP;
            else if (wb_ack)
               state_nxt = more_beats ? S_BEAT : S_RESP;
            else if (tmr_expired)
               state_nxt = S_RESP;
         end
         S_RESP:  state_nxt = S_IDLE;
         S_BEAT:  state_nxt = is_write ? S_WDATA : S_WB;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(negedge nub_clkn or negedge nub_resetn) begin
      if (!nub_resetn) begin
         state    <= S_IDLE;
         status   <= STAT_COMPLETE;
         is_write <= 1'b0;
         wb_adr   <= '0;
         wb_dat_w <= '0;
         wb_sel   <= '0;
         ad_o     <= '0;
`ifdef NUBUS_SLAVE_BLOCK_EN
         is_block  <= 1'b0;
         beat_idx  <= '0;
         beat_last <= '0;
`endif
      end else begin
         state <= state_nxt;
         case (state)
            S_IDLE: if (claim) begin
               is_write <= tm1;
               wb_sel   <= tm1 ? sel : 4'hF;
               wb_adr   <= {6'd0, ad[25:2]};
               status   <= blk_reject ? STAT_ERROR : STAT_COMPLETE;
`ifdef NUBUS_SLAVE_BLOCK_EN
               is_block  <= block;
               beat_idx  <= '0;
               beat_last <= blk_info[3:0];
               if (block) wb_adr <= {6'd0, ad[25:6], 4'd0};
`endif
            end
            S_WDATA: wb_dat_w <= ad;
            S_WB: begin
               if (wb_err)
                  status <= STAT_ERROR;
               else if (wb_ack) begin
                  status <= STAT_COMPLETE;
                  if (!is_write) ad_o <= wb_dat_r;
`ifdef NUBUS_SLAVE_BLOCK_EN
                  if (more_beats) begin
                     beat_idx    <= beat_idx + 4'd1;
                     wb_adr[3:0] <= beat_idx + 4'd1;
                  end
`endif
               end else if (tmr_expired)
                  status <= STAT_TIMEOUT;
            end
            default: ;
         endcase
      end
   end

   // Reloaded whenever outside WB, so each Wishbone access gets exactly TIMEOUT cycles
   nubus_slave_timer #(.W(TW)) u_timer (
      .nub_clkn   (nub_clkn),
      .nub_resetn (nub_resetn),
      .load       (state != S_WB),
      .en         (state == S_WB),
      .load_val   (TW'(TIMEOUT - 1)),
      .expired    (tmr_expired)
   );

   assign wb_cyc = (state == S_WB);
   assign wb_stb = wb_cyc;
   assign wb_we  = wb_cyc & is_write;
   assign ack_o  = (state == S_RESP);
   assign tm1_o  = ack_o & status[1];
   assign tm0_o  = (ack_o & status[0]) | (state == S_BEAT);
   assign ad_oe  = ~is_write & ((ack_o & (status == STAT_COMPLETE)) | (state == S_BEAT));

endmodule
